// File: rtl/rx_fifo.sv
// rx_fifo: receive-side byte FIFO with first-word-fall-through read port,
// registered occupancy count and a sticky overflow flag for dropped pushes.
module rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  ovf_q;

  logic do_pop;
  logic do_push;
  logic drop;

  // Status decode and accept/drop qualification; a full FIFO still accepts a
  // push when the head is popped in the same cycle.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_COUNT);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~pop;
    rdata   = empty ? '0 : mem[rd_ptr];
  end

  assign count    = count_q;
  assign overflow = ovf_q;

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule
